// File: rtl/sar_search.sv
// rtl/sar_search.sv - MSB-first successive-approximation search driving a magnitude comparator
module sar_search #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             aeb,
    input  logic             agb,
    input  logic             alb,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] TEST   = 2'd1;
    localparam logic [1:0] VERIFY = 2'd2;

    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IW-1:0]    IDX_TOP  = IW'(WIDTH - 1);

    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] next_guess;
    logic             onehot;

    // Comparator health: exactly one of the three flags may be high.
    always_comb begin
        onehot = (aeb ^ agb ^ alb) & ~(aeb & agb & alb);
    end

    // Resolve the bit under test (drop it when the guess was too big) and
    // tentatively set the next lower bit for the following comparison.
    always_comb begin
        next_guess = guess;
        if (agb) begin
            next_guess[idx] = 1'b0;
        end
        if (idx != '0) begin
            next_guess[idx - 1'b1] = 1'b1;
        end
    end

    // Search sequencer: launch, walk the bits MSB first, then report.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            guess  <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            found  <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        guess <= MSB_ONLY;
                        idx   <= IDX_TOP;
                        busy  <= 1'b1;
                        found <= 1'b0;
                        err   <= 1'b0;
                        state <= TEST;
                    end
                end
                TEST: begin
                    if (!onehot) begin
                        err    <= 1'b1;
                        found  <= 1'b0;
                        result <= guess;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else if (aeb) begin
                        result <= guess;
                        found  <= 1'b1;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        guess <= next_guess;
                        if (idx != '0) begin
                            idx <= idx - 1'b1;
                        end else begin
                            state <= VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    result <= guess;
                    found  <= aeb;
                    err    <= ~onehot;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
